// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types and constants for the 8-slot parking controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int SLOT_COUNT = 8;

    typedef logic [2:0]            slot_idx_t;
    typedef logic [SLOT_COUNT-1:0] occ_map_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_ENTER = 1'b0,
        REQ_EXIT  = 1'b1
    } req_kind_t;

    function automatic logic [3:0] count_free(input occ_map_t map);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            n = n + {3'b000, ~map[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parking_slot_controller_free_slot_finder.sv
// ============================================================================
// Module   : free_slot_finder
// Purpose  : Combinational lowest-zero-bit search over the occupancy map.
// Revision : 1.0
// ============================================================================
`default_nettype none

module free_slot_finder
    import parking_pkg::*;
(
    input  logic [SLOT_COUNT-1:0] occ_map_i,
    output logic [2:0]            free_idx_o,
    output logic                  any_free_o
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx_o = 3'd0;
        any_free_o = 1'b0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (!occ_map_i[i]) begin
                free_idx_o = i[2:0];
                any_free_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/parking_slot_controller.sv
// ============================================================================
// Module   : parking_slot_controller
// Purpose  : Arbitrates entry/exit handshakes and owns the occupancy map.
//            Define PARK_RR_ARB_EN for round-robin tie arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module parking_slot_controller
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_req,
    output logic       enter_ack,
    output logic       enter_ok,
    output logic [2:0] enter_slot,
    input  logic       exit_req,
    input  logic [2:0] exit_slot,
    output logic       exit_ack,
    output logic       exit_ok,
    output logic [7:0] parking_capacity,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty
);

    state_t    r_state_q,      w_state_d;
    req_kind_t r_kind_q,       w_kind_d;
    slot_idx_t r_slot_q,       w_slot_d;
    occ_map_t  r_cap_q,        w_cap_d;
    logic      r_enter_ack_q,  w_enter_ack_d;
    logic      r_exit_ack_q,   w_exit_ack_d;
    logic      r_enter_ok_q,   w_enter_ok_d;
    logic      r_exit_ok_q,    w_exit_ok_d;
    slot_idx_t r_enter_slot_q, w_enter_slot_d;
`ifdef PARK_RR_ARB_EN
    req_kind_t r_last_q,       w_last_d;
`endif

    req_kind_t w_winner;
    slot_idx_t w_free_idx;
    logic      w_any_free;
    occ_map_t  w_mask;
    logic      w_served_req;

    free_slot_finder u_finder (
        .occ_map_i  (r_cap_q),
        .free_idx_o (w_free_idx),
        .any_free_o (w_any_free)
    );

    always_comb begin
`ifdef PARK_RR_ARB_EN
        if (enter_req && exit_req) begin
            w_winner = (r_last_q == REQ_EXIT) ? REQ_ENTER : REQ_EXIT;
        end else begin
            w_winner = exit_req ? REQ_EXIT : REQ_ENTER;
        end
`else
        w_winner = exit_req ? REQ_EXIT : REQ_ENTER;
`endif
    end

    // Mask is zero whenever the request is refused, so the XOR commit is a no-op.
    always_comb begin
        w_mask = '0;
        if (r_kind_q == REQ_ENTER) begin
            if (w_any_free) begin
                w_mask = occ_map_t'(1) << w_free_idx;
            end
        end else if (r_cap_q[r_slot_q]) begin
            w_mask = occ_map_t'(1) << r_slot_q;
        end
    end

    assign w_served_req = (r_kind_q == REQ_ENTER) ? enter_req : exit_req;

    always_comb begin
        w_state_d      = r_state_q;
        w_kind_d       = r_kind_q;
        w_slot_d       = r_slot_q;
        w_cap_d        = r_cap_q;
        w_enter_ack_d  = r_enter_ack_q;
        w_exit_ack_d   = r_exit_ack_q;
        w_enter_ok_d   = r_enter_ok_q;
        w_exit_ok_d    = r_exit_ok_q;
        w_enter_slot_d = r_enter_slot_q;
`ifdef PARK_RR_ARB_EN
        w_last_d       = r_last_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (enter_req || exit_req) begin
                    w_kind_d  = w_winner;
                    w_state_d = EVAL;
                    if (w_winner == REQ_EXIT) begin
                        w_slot_d = exit_slot;
                    end
`ifdef PARK_RR_ARB_EN
                    w_last_d = w_winner;
`endif
                end
            end
            EVAL: begin
                w_cap_d = r_cap_q ^ w_mask;
                if (r_kind_q == REQ_ENTER) begin
                    w_enter_ack_d = 1'b1;
                    w_enter_ok_d  = w_any_free;
                    if (w_any_free) begin
                        w_enter_slot_d = w_free_idx;
                    end
                end else begin
                    w_exit_ack_d = 1'b1;
                    w_exit_ok_d  = r_cap_q[r_slot_q];
                end
                w_state_d = ACK;
            end
            ACK: begin
                if (!w_served_req) begin
                    w_enter_ack_d = 1'b0;
                    w_exit_ack_d  = 1'b0;
                    w_state_d     = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_kind_q       <= REQ_ENTER;
            r_slot_q       <= '0;
            r_cap_q        <= '0;
            r_enter_ack_q  <= 1'b0;
            r_exit_ack_q   <= 1'b0;
            r_enter_ok_q   <= 1'b0;
            r_exit_ok_q    <= 1'b0;
            r_enter_slot_q <= '0;
`ifdef PARK_RR_ARB_EN
            r_last_q       <= REQ_EXIT;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_kind_q       <= w_kind_d;
            r_slot_q       <= w_slot_d;
            r_cap_q        <= w_cap_d;
            r_enter_ack_q  <= w_enter_ack_d;
            r_exit_ack_q   <= w_exit_ack_d;
            r_enter_ok_q   <= w_enter_ok_d;
            r_exit_ok_q    <= w_exit_ok_d;
            r_enter_slot_q <= w_enter_slot_d;
`ifdef PARK_RR_ARB_EN
            r_last_q       <= w_last_d;
`endif
        end
    end

    assign enter_ack        = r_enter_ack_q;
    assign enter_ok         = r_enter_ok_q;
    assign enter_slot       = r_enter_slot_q;
    assign exit_ack         = r_exit_ack_q;
    assign exit_ok          = r_exit_ok_q;
    assign parking_capacity = r_cap_q;
    assign free_count       = count_free(r_cap_q);
    assign full             = &r_cap_q;
    assign empty            = ~|r_cap_q;

endmodule

`default_nettype wire

// File: tb/tb_parking_slot_controller.sv
// ============================================================================
// Module   : tb_parking_slot_controller
// Purpose  : Directed and randomized self-checking bench with a behavioural
//            occupancy model. Honours PARK_RR_ARB_EN for tie expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_parking_slot_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_req;
    logic       enter_ack;
    logic       enter_ok;
    logic [2:0] enter_slot;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       exit_ack;
    logic       exit_ok;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_map;
    bit         m_last_exit;

    parking_slot_controller dut (
        .clk              (clk),
        .reset            (reset),
        .enter_req        (enter_req),
        .enter_ack        (enter_ack),
        .enter_ok         (enter_ok),
        .enter_slot       (enter_slot),
        .exit_req         (exit_req),
        .exit_slot        (exit_slot),
        .exit_ack         (exit_ack),
        .exit_ok          (exit_ok),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free(input logic [7:0] map);
        for (int i = 0; i < 8; i++) begin
            if (!map[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_status();
        chk("map", parking_capacity, m_map);
        chk("free_count", free_count, 8 - $countones(m_map));
        chk("full", full, m_map == 8'hFF);
        chk("empty", empty, m_map == 8'h00);
    endtask

    task automatic model_reset();
        m_map       = 8'h00;
        m_last_exit = 1'b1;
    endtask

    // Waits for the served ack, checks the outcome against the model, then
    // drops the request and confirms the ack falls on the next edge.
    task automatic finish(input bit is_exit, input logic [2:0] s, input int exp_lat);
        int n;
        int idx;
        bit exp_ok;
        n = 0;
        while ((is_exit ? exit_ack : enter_ack) !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(is_exit ? "exit_ack_rise" : "enter_ack_rise", is_exit ? exit_ack : enter_ack, 1);
        chk("ack_latency", n, exp_lat);
        chk("other_ack_low", is_exit ? enter_ack : exit_ack, 0);
        m_last_exit = is_exit;
        if (!is_exit) begin
            idx    = lowest_free(m_map);
            exp_ok = (idx >= 0);
            chk("enter_ok", enter_ok, exp_ok);
            if (exp_ok) begin
                chk("enter_slot", enter_slot, idx);
                m_map[idx] = 1'b1;
            end
        end else begin
            exp_ok = m_map[s];
            chk("exit_ok", exit_ok, exp_ok);
            if (exp_ok) m_map[s] = 1'b0;
        end
        check_status();
        if (is_exit) exit_req = 1'b0;
        else         enter_req = 1'b0;
        tick();
        chk("ack_fall", is_exit ? exit_ack : enter_ack, 0);
        chk("map_hold", parking_capacity, m_map);
    endtask

    task automatic do_enter();
        enter_req = 1'b1;
        finish(1'b0, 3'd0, 2);
    endtask

    task automatic do_exit(input logic [2:0] s);
        exit_req  = 1'b1;
        exit_slot = s;
        finish(1'b1, s, 2);
    endtask

    task automatic do_tie(input logic [2:0] s);
        bit win_exit;
        enter_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = s;
`ifdef PARK_RR_ARB_EN
        win_exit = !m_last_exit;
`else
        win_exit = 1'b1;
`endif
        finish(win_exit, s, 2);
        finish(!win_exit, s, 2);
    endtask

    initial begin
        reset     = 1'b1;
        enter_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 3'd0;
        model_reset();
        tick();
        tick();
        chk("rst_enter_ack", enter_ack, 0);
        chk("rst_exit_ack", exit_ack, 0);
        chk("rst_enter_ok", enter_ok, 0);
        chk("rst_exit_ok", exit_ok, 0);
        chk("rst_enter_slot", enter_slot, 0);
        check_status();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_enter();
        chk("fill_map", parking_capacity, 8'hFF);
        do_enter();
        do_exit(3'd5);
        chk("after_exit5", parking_capacity, 8'hDF);
        do_enter();
        for (int i = 0; i < 8; i++) do_exit(i[2:0]);
        do_exit(3'd3);
        chk("empty_after_bad_exit", empty, 1);

        // Tie at map 8'h01 with exit last served
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        do_enter();
        do_exit(3'd7);
        chk("tie_setup", parking_capacity, 8'h01);
        do_tie(3'd0);

        // Latched exit slot must ignore later exit_slot changes
        for (int i = 0; i < 3; i++) do_enter();
        exit_req  = 1'b1;
        exit_slot = 3'd2;
        tick();
        exit_slot = 3'd6;
        finish(1'b1, 3'd2, 1);

        // Reset during ACK of an entry discards the transaction
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        do_enter();
        enter_req = 1'b1;
        tick();
        tick();
        chk("pre_reset_ack", enter_ack, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("reset_enter_ack", enter_ack, 0);
        chk("reset_exit_ack", exit_ack, 0);
        chk("reset_enter_ok", enter_ok, 0);
        check_status();
        finish(1'b0, 3'd0, 2);
        chk("reserved_slot0", parking_capacity, 8'h01);

        for (int i = 0; i < 80; i++) begin
            int r;
            logic [2:0] s;
            r = $urandom_range(0, 2);
            s = 3'($urandom_range(0, 7));
            if (r == 0)      do_enter();
            else if (r == 1) do_exit(s);
            else             do_tie(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
